// File: rtl/montgomery_mul_iter.sv
// Word-serial Montgomery multiplier: y = a*b*R^-1 mod m (or a*R^-1 mod m), R = 2^NBITS.
// Each radix-2^W word of a takes one ACC cycle and one RED cycle, followed by one final subtraction.
module montgomery_mul_iter #(
   parameter int NBITS = 256,
   parameter int W     = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_p,
   input  logic             mode,
   input  logic [NBITS-1:0] a,
   input  logic [NBITS-1:0] b,
   input  logic [NBITS-1:0] m,
   input  logic [W-1:0]     m_inv,
   output logic [NBITS-1:0] y,
   output logic             busy,
   output logic             done_irq_p
);

   localparam int L  = NBITS / W;
   localparam int UW = NBITS + W + 2;
   localparam int IW = (L > 1) ? $clog2(L) : 1;

   generate
      if ((W > NBITS) || ((NBITS % W) != 0)) begin : g_bad_params
         $error("montgomery_mul_iter: NBITS must be a non-zero multiple of W");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ACC, RED, FINAL} state_t;

   state_t           state_q, state_d;
   logic [NBITS-1:0] a_q, a_d;
   logic [NBITS-1:0] b_q, b_d;
   logic [NBITS-1:0] m_q, m_d;
   logic [W-1:0]     minv_q, minv_d;
   logic [UW-1:0]    u_q, u_d;
   logic [W-1:0]     q_q, q_d;
   logic [IW-1:0]    i_q, i_d;
   logic [NBITS-1:0] y_q, y_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [UW-1:0]    a_word_ext, b_ext, q_ext, m_ext;
   logic [UW-1:0]    acc_sum, red_sum;
   logic [W-1:0]     q_calc;

   // a_q is shifted down one word per RED, so the current digit is always its low word.
   assign a_word_ext = {{(UW-W){1'b0}}, a_q[W-1:0]};
   assign b_ext      = {{(UW-NBITS){1'b0}}, b_q};
   assign q_ext      = {{(UW-W){1'b0}}, q_q};
   assign m_ext      = {{(UW-NBITS){1'b0}}, m_q};

   assign acc_sum = u_q + a_word_ext * b_ext;
   assign q_calc  = acc_sum[W-1:0] * minv_q;
   assign red_sum = u_q + q_ext * m_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
         minv_q  <= '0;
         u_q     <= '0;
         q_q     <= '0;
         i_q     <= '0;
         y_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         minv_q  <= minv_d;
         u_q     <= u_d;
         q_q     <= q_d;
         i_q     <= i_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      m_d     = m_q;
      minv_d  = minv_q;
      u_d     = u_q;
      q_d     = q_q;
      i_d     = i_q;
      y_d     = y_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_p) begin
               a_d     = a;
               b_d     = mode ? {{(NBITS-1){1'b0}}, 1'b1} : b;
               m_d     = m;
               minv_d  = m_inv;
               u_d     = '0;
               i_d     = '0;
               busy_d  = 1'b1;
               state_d = ACC;
            end
         end
         ACC: begin
            u_d     = acc_sum;
            q_d     = q_calc;
            state_d = RED;
         end
         RED: begin
            // Low W bits of red_sum are zero because q was chosen to cancel them.
            u_d = red_sum >> W;
            a_d = a_q >> W;
            if (i_q == IW'(L - 1)) begin
               state_d = FINAL;
            end else begin
               i_d     = i_q + IW'(1);
               state_d = ACC;
            end
         end
         FINAL: begin
            y_d     = (u_q >= m_ext) ? (u_q[NBITS-1:0] - m_q) : u_q[NBITS-1:0];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign y          = y_q;
   assign busy       = busy_q;
   assign done_irq_p = done_q;

endmodule

// File: tb/tb_montgomery_mul_iter.sv
// Bench for montgomery_mul_iter: directed 8/4 cases plus random 16/8 and 256/64 sweeps
// against a bit-serial modular-halving reference.
module tb_montgomery_mul_iter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        en0 = 0, md0 = 0;
   logic [7:0]  a0 = 0, b0 = 0, m0 = 0, y0;
   logic [3:0]  iv0 = 0;
   logic        busy0, done0;

   logic        en1 = 0, md1 = 0;
   logic [15:0] a1 = 0, b1 = 0, m1 = 0, y1;
   logic [7:0]  iv1 = 0;
   logic        busy1, done1;

   logic         en2 = 0, md2 = 0;
   logic [255:0] a2 = 0, b2 = 0, m2 = 0, y2;
   logic [63:0]  iv2 = 0;
   logic         busy2, done2;

   montgomery_mul_iter #(.NBITS(8), .W(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .enable_p(en0), .mode(md0), .a(a0), .b(b0), .m(m0),
      .m_inv(iv0), .y(y0), .busy(busy0), .done_irq_p(done0));
   montgomery_mul_iter #(.NBITS(16), .W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .enable_p(en1), .mode(md1), .a(a1), .b(b1), .m(m1),
      .m_inv(iv1), .y(y1), .busy(busy1), .done_irq_p(done1));
   montgomery_mul_iter #(.NBITS(256), .W(64)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .enable_p(en2), .mode(md2), .a(a2), .b(b2), .m(m2),
      .m_inv(iv2), .y(y2), .busy(busy2), .done_irq_p(done2));

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] gen_m(input int n);
      logic [255:0] r;
      r = rnd256() & ((256'd1 << n) - 256'd1);
      r[n-1] = 1'b1;
      r[0] = 1'b1;
      return r;
   endfunction

   // -m^-1 mod 2^w via Newton iteration on the odd modulus
   function automatic logic [63:0] calc_minv(input logic [255:0] mv, input int w);
      logic [63:0] x, inv;
      x = mv[63:0];
      inv = x;
      for (int k = 0; k < 6; k++) inv = inv * (64'd2 - x * inv);
      return (-inv) & ((64'd1 << w) - 64'd1);
   endfunction

   // a*b mod m, then divide by 2 modulo m, n times
   function automatic logic [255:0] ref_mont(input logic [255:0] av, bv, mv, input logic md,
                                             input int n);
      logic [511:0] p, mm, bb;
      mm = {256'd0, mv};
      bb = md ? 512'd1 : {256'd0, bv};
      p = ({256'd0, av} * bb) % mm;
      for (int k = 0; k < n; k++) p = p[0] ? ((p + mm) >> 1) : (p >> 1);
      return p[255:0];
   endfunction

   task automatic drive(input int which, input logic [255:0] av, bv, mv, input logic [63:0] iv,
                        input logic md, input logic en);
      case (which)
         0: begin a0 = av[7:0]; b0 = bv[7:0]; m0 = mv[7:0]; iv0 = iv[3:0]; md0 = md; en0 = en; end
         1: begin a1 = av[15:0]; b1 = bv[15:0]; m1 = mv[15:0]; iv1 = iv[7:0]; md1 = md; en1 = en; end
         default: begin a2 = av; b2 = bv; m2 = mv; iv2 = iv; md2 = md; en2 = en; end
      endcase
   endtask

   function automatic logic [255:0] get_y(input int which);
      case (which)
         0: return {248'd0, y0};
         1: return {240'd0, y1};
         default: return y2;
      endcase
   endfunction

   function automatic logic get_done(input int which);
      case (which)
         0: return done0;
         1: return done1;
         default: return done2;
      endcase
   endfunction

   function automatic logic get_busy(input int which);
      case (which)
         0: return busy0;
         1: return busy1;
         default: return busy2;
      endcase
   endfunction

   // Starts an op from the current cycle and waits for its done pulse.
   task automatic do_op(input int which, input logic [255:0] av, bv, mv, input logic [63:0] iv,
                        input logic md, output logic [255:0] yv, output int lat);
      drive(which, av, bv, mv, iv, md, 1'b1);
      @(posedge clk); #1;
      drive(which, av, bv, mv, iv, md, 1'b0);
      chk("busy_after_start", {255'd0, get_busy(which)}, 256'd1);
      lat = 0;
      while (!get_done(which) && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("done_seen", {255'd0, get_done(which)}, 256'd1);
      chk("busy_at_done", {255'd0, get_busy(which)}, 256'd0);
      yv = get_y(which);
      $display("op inst=%0d mode=%0d a=%0h b=%0h m=%0h -> y=%0h lat=%0d", which, md, av, bv, mv,
               yv, lat);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] yv, mv, av, bv, yprev;
      logic [63:0]  iv;
      int lat, ndone, dlat, ystab_bad, last_done, intv_bad, nb, nw;
      logic md;

      #23;
      chk("rst_y0", {248'd0, y0}, 256'd0);
      chk("rst_busy0", {255'd0, busy0}, 256'd0);
      chk("rst_done0", {255'd0, done0}, 256'd0);
      chk("rst_y2", y2, 256'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_y0", {248'd0, y0}, 256'd0);
      chk("post_rst_done0", {255'd0, done0}, 256'd0);

      // Directed NBITS=8, W=4 cases
      do_op(0, 256'h01, 256'h01, 256'hE5, 64'h3, 1'b0, yv, lat);
      chk("one_by_one_y", yv, 256'h11);
      chk("one_by_one_lat", lat, 5);
      do_op(0, 256'h1B, 256'h64, 256'hE5, 64'h3, 1'b0, yv, lat);
      chk("rmodm_y", yv, 256'h64);
      do_op(0, 256'hE4, 256'hE4, 256'hE5, 64'h3, 1'b0, yv, lat);
      chk("b2b_y", yv, 256'h11);
      chk("b2b_lat", lat, 5);
      do_op(0, 256'h1B, 256'hAA, 256'hE5, 64'h3, 1'b1, yv, lat);
      chk("mode1_y", yv, 256'h01);
      do_op(0, 256'h00, 256'h55, 256'hE5, 64'h3, 1'b0, yv, lat);
      chk("zero_y", yv, 256'h00);

      // Enable pulses while busy with changed a are ignored
      repeat (2) @(posedge clk);
      #1;
      yprev = {248'd0, y0};
      drive(0, 256'h1B, 256'h64, 256'hE5, 64'h3, 1'b0, 1'b1);
      @(posedge clk); #1;
      en0 = 1'b0;
      ndone = 0; dlat = 0; ystab_bad = 0; yv = 0;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin en0 = 1'b1; a0 = 8'h01; end
         if (c == 3) en0 = 1'b0;
         if (c < 5 && {248'd0, y0} !== yprev) ystab_bad++;
         if (done0) begin ndone++; dlat = c; yv = {248'd0, y0}; end
      end
      chk("ignore_ndone", ndone, 1);
      chk("ignore_lat", dlat, 5);
      chk("ignore_y", yv, 256'h64);
      chk("y_stable_while_busy", ystab_bad, 0);
      chk("ignore_idle_after", {255'd0, busy0}, 256'd0);

      // Reset mid-operation
      drive(0, 256'h01, 256'h01, 256'hE5, 64'h3, 1'b0, 1'b1);
      @(posedge clk); #1;
      en0 = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_y", {248'd0, y0}, 256'd0);
      chk("abort_busy", {255'd0, busy0}, 256'd0);
      ndone = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (done0) ndone++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (done0) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      do_op(0, 256'hE4, 256'hE4, 256'hE5, 64'h3, 1'b0, yv, lat);
      chk("after_abort_y", yv, 256'h11);
      chk("after_abort_lat", lat, 5);

      // Random sweeps on 16/8 and 256/64
      for (int which = 1; which <= 2; which++) begin
         nb = (which == 1) ? 16 : 256;
         nw = (which == 1) ? 8 : 64;
         for (int t = 0; t < 20; t++) begin
            mv = gen_m(nb);
            av = rnd256() % mv;
            bv = rnd256() % mv;
            iv = calc_minv(mv, nw);
            md = t[0];
            do_op(which, av, bv, mv, iv, md, yv, lat);
            chk("rand_y", yv, ref_mont(av, bv, mv, md, nb));
            chk("rand_lt_m", {255'd0, yv < mv}, 256'd1);
            chk("rand_lat", lat, 2 * (nb / nw) + 1);
         end
      end

      // Enable held high: one result every 2L+2 cycles
      mv = gen_m(16);
      av = rnd256() % mv;
      bv = rnd256() % mv;
      drive(1, av, bv, mv, calc_minv(mv, 8), 1'b0, 1'b1);
      ndone = 0; last_done = -1; intv_bad = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (done1) begin
            if (last_done >= 0 && c - last_done != 6) intv_bad++;
            last_done = c;
            ndone++;
         end
      end
      en1 = 1'b0;
      chk("held_en_count", {255'd0, ndone >= 4}, 256'd1);
      chk("held_en_interval", intv_bad, 0);
      chk("held_en_y", {240'd0, y1}, ref_mont(av, bv, mv, 1'b0, 16));
      repeat (8) @(posedge clk);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
